// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search controller driving an external magnitude comparator.
// One compare window (CMP_LAT+1 cycles) per trial bit, plus one VERIFY window if no early equality.
module sar_search_ctrl #(
   parameter int WIDTH   = 4,
   parameter int CMP_LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] trial,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

   localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CMP_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TEST   = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] bit_idx;
   logic [IDX_W-1:0] bit_idx_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_nxt;
   logic [WIDTH-1:0] trial_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic [WIDTH-1:0] cand;
   logic             busy_nxt;
   logic             done_nxt;
   logic             found_nxt;
   logic             err_nxt;
   logic             sample;
   logic             flags_ok;
   logic             finish;

   assign sample   = (wait_cnt == CNT_LAST);
   // Exactly one of the three comparator flags may be asserted.
   assign flags_ok = (cmp_gt ^ cmp_lt ^ cmp_eq) & ~(cmp_gt & cmp_lt & cmp_eq);

   always_comb begin
      state_nxt   = state;
      trial_nxt   = trial;
      bit_idx_nxt = bit_idx;
      wait_nxt    = wait_cnt;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      result_nxt  = result;
      found_nxt   = found;
      err_nxt     = err;
      cand        = trial;
      finish      = 1'b0;

      case (state)
         IDLE: begin
            trial_nxt = '0;
            if (start) begin
               trial_nxt   = TRIAL_MSB;
               bit_idx_nxt = IDX_TOP;
               wait_nxt    = '0;
               busy_nxt    = 1'b1;
               found_nxt   = 1'b0;
               err_nxt     = 1'b0;
               state_nxt   = TEST;
            end
         end

         TEST, VERIFY: begin
            if (!sample) begin
               wait_nxt = wait_cnt + CNT_ONE;
            end else if (!flags_ok) begin
               err_nxt    = 1'b1;
               found_nxt  = 1'b0;
               result_nxt = trial;
               finish     = 1'b1;
            end else if (state == VERIFY) begin
               found_nxt  = cmp_eq;
               err_nxt    = ~cmp_eq;
               result_nxt = trial;
               finish     = 1'b1;
            end else if (cmp_eq) begin
               result_nxt = trial;
               found_nxt  = 1'b1;
               finish     = 1'b1;
            end else begin
               // Trial too large: drop the bit under test before moving down.
               if (cmp_gt) begin
                  cand[bit_idx] = 1'b0;
               end
               wait_nxt = '0;
               if (bit_idx != IDX_ZERO) begin
                  cand[bit_idx - IDX_ONE] = 1'b1;
                  bit_idx_nxt             = bit_idx - IDX_ONE;
               end else begin
                  state_nxt = VERIFY;
               end
               trial_nxt = cand;
            end
         end

         DONE: begin
            trial_nxt = '0;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (finish) begin
         state_nxt = DONE;
         done_nxt  = 1'b1;
         busy_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         trial    <= '0;
         bit_idx  <= '0;
         wait_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         found    <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         trial    <= trial_nxt;
         bit_idx  <= bit_idx_nxt;
         wait_cnt <= wait_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         result   <= result_nxt;
         found    <= found_nxt;
         err      <= err_nxt;
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: one combinational-comparator instance and one with a 2-cycle comparator.
module tb_sar_search_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic       bad;
   logic       sel;
   logic [3:0] tgt;

   logic       start0, start2;
   logic [3:0] trial0, res0, trial2, res2;
   logic       busy0, done0, found0, err0;
   logic       busy2, done2, found2, err2;
   logic       gt0, lt0, eq0, gt2, lt2, eq2;
   logic [3:0] d1, d2;

   assign start0 = start & ~sel;
   assign start2 = start & sel;

   // Instance 0: ideal combinational comparator, optionally forced to an illegal gt=lt=1.
   assign gt0 = bad | (trial0 > tgt);
   assign lt0 = bad | (trial0 < tgt);
   assign eq0 = ~bad & (trial0 == tgt);

   // Instance 2: comparator whose flags only reflect a trial two cycles after it changes.
   always @(posedge clk) begin
      d1 <= trial2;
      d2 <= d1;
   end
   assign gt2 = (d2 > tgt);
   assign lt2 = (d2 < tgt);
   assign eq2 = (d2 == tgt);

   sar_search_ctrl #(.WIDTH(4), .CMP_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .trial(trial0),
      .cmp_gt(gt0), .cmp_lt(lt0), .cmp_eq(eq0),
      .busy(busy0), .done(done0), .result(res0), .found(found0), .err(err0)
   );

   sar_search_ctrl #(.WIDTH(4), .CMP_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .trial(trial2),
      .cmp_gt(gt2), .cmp_lt(lt2), .cmp_eq(eq2),
      .busy(busy2), .done(done2), .result(res2), .found(found2), .err(err2)
   );

   logic [3:0] o_trial, o_res;
   logic       o_busy, o_done, o_found, o_err;
   assign o_trial = sel ? trial2 : trial0;
   assign o_res   = sel ? res2   : res0;
   assign o_busy  = sel ? busy2  : busy0;
   assign o_done  = sel ? done2  : done0;
   assign o_found = sel ? found2 : found0;
   assign o_err   = sel ? err2   : err0;

   typedef struct {
      logic [3:0] res;
      logic       found;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] exp_trials[$];
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Cycle c is the state seen just after the (c-1)th edge following the start edge.
   task automatic run_search(input logic s, input logic [3:0] t, input int lat,
                             input logic [3:0] e_res, input logic e_found, input logic e_err,
                             input int e_done, input int fault_c, input int busy_start_c,
                             input logic done_start);
      exp_t       e;
      exp_t       pushed;
      logic [3:0] cur;
      int         c;
      int         per;
      logic       seen;
      sel  = s;
      tgt  = t;
      pushed.res   = e_res;
      pushed.found = e_found;
      pushed.err   = e_err;
      pushed.cyc   = e_done;
      sb.push_back(pushed);
      e    = pushed;
      cur  = 4'd0;
      per  = lat + 1;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c = 1;
      while (!seen && c <= 40) begin
         start = (c == busy_start_c);
         bad   = (c == fault_c);
         #0;
         if (((c - 1) % per) == 0 && exp_trials.size() > 0) cur = exp_trials.pop_front();
         if (o_done === 1'b1) begin
            seen = 1'b1;
            e = sb.pop_front();
            chk("done_cycle", c, e.cyc);
            chk("result", o_res, e.res);
            chk("found", o_found, e.found);
            chk("err", o_err, e.err);
            chk("busy_at_done", o_busy, 0);
            start = done_start;
         end else begin
            chk("busy_during", o_busy, 1);
            chk("trial", o_trial, cur);
         end
         @(posedge clk);
         #1;
         c++;
      end
      start = 1'b0;
      bad   = 1'b0;
      exp_trials.delete();
      chk("done_seen", seen, 1);
      chk("done_pulse_end", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_trial", o_trial, 0);
      chk("result_held", o_res, e.res);
      @(posedge clk);
      #1;
      chk("still_idle", o_busy, 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      bad   = 1'b0;
      sel   = 1'b0;
      tgt   = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_trial0", trial0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_result0", res0, 0);
      chk("rst_found0", found0, 0);
      chk("rst_err0", err0, 0);
      chk("rst_trial2", trial2, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_done2", done2, 0);
      chk("rst_result2", res2, 0);
      chk("rst_found2", found2, 0);
      chk("rst_err2", err2, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // target 5, start pulsed during DONE must be ignored
      exp_trials = '{4'd8, 4'd4, 4'd6, 4'd5};
      run_search(1'b0, 4'd5, 0, 4'd5, 1'b1, 1'b0, 5, 0, 0, 1'b1);

      // target 0 reaches VERIFY with trial 0
      exp_trials = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
      run_search(1'b0, 4'd0, 0, 4'd0, 1'b1, 1'b0, 6, 0, 0, 1'b0);

      // first trial equal: minimum latency
      exp_trials = '{4'd8};
      run_search(1'b0, 4'd8, 0, 4'd8, 1'b1, 1'b0, 2, 0, 0, 1'b0);

      // all-ones target
      exp_trials = '{4'd8, 4'd12, 4'd14, 4'd15};
      run_search(1'b0, 4'd15, 0, 4'd15, 1'b1, 1'b0, 5, 0, 0, 1'b0);

      // 3-cycle compare windows
      exp_trials = '{4'd8, 4'd12, 4'd10, 4'd9};
      run_search(1'b1, 4'd9, 2, 4'd9, 1'b1, 1'b0, 13, 0, 0, 1'b0);

      // 3-cycle windows through VERIFY (max compares)
      exp_trials = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
      run_search(1'b1, 4'd0, 2, 4'd0, 1'b1, 1'b0, 16, 0, 0, 1'b0);

      // illegal flags on 2nd compare; start pulsed while busy in cycle 1
      exp_trials = '{4'd8, 4'd4};
      run_search(1'b0, 4'd5, 0, 4'd4, 1'b0, 1'b1, 3, 2, 1, 1'b0);

      // reset mid-search
      sel = 1'b0;
      tgt = 4'd5;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_trial", trial0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_done", done0, 0);
      chk("mid_rst_result", res0, 0);
      chk("mid_rst_found", found0, 0);
      chk("mid_rst_err", err0, 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("no_done_after_rst", done0, 0);
      end

      exp_trials = '{4'd8, 4'd12, 4'd10, 4'd11};
      run_search(1'b0, 4'd11, 0, 4'd11, 1'b1, 1'b0, 5, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
